// File: rtl/ir_nec_pkg.sv
// NEC IR link constants, state encoding and frame layout shared by transmitter and receiver.
// Timing values are cycles of the 50 MHz core clock.
package ir_nec_pkg;
   localparam int unsigned LEAD_MARK    = 450000;
   localparam int unsigned LEAD_SPACE   = 225000;
   localparam int unsigned BIT_MARK     = 28000;
   localparam int unsigned ZERO_SPACE   = 28000;
   localparam int unsigned ONE_SPACE    = 84500;
   localparam int unsigned GAP_DUR      = 2000000;
   localparam int unsigned CARRIER_HALF = 658;

   localparam int unsigned PH_CNT_W  = 21;
   localparam int unsigned CAR_CNT_W = 11;

   localparam int unsigned ADDR_LSB = 0;
   localparam int unsigned ADDR_MSB = 15;
   localparam int unsigned CMD_LSB  = 16;
   localparam int unsigned CMD_MSB  = 23;
   localparam int unsigned NCMD_LSB = 24;
   localparam int unsigned NCMD_MSB = 31;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEAD_M = 3'd1,
      S_LEAD_S = 3'd2,
      S_BIT_M  = 3'd3,
      S_BIT_S  = 3'd4,
      S_STOP_M = 3'd5,
      S_GAP    = 3'd6
   } state_t;

   function automatic logic [31:0] nec_frame(input logic [15:0] addr, input logic [7:0] cmd);
      logic [31:0] f;
      f = '0;
      f[ADDR_MSB:ADDR_LSB] = addr;
      f[CMD_MSB:CMD_LSB]   = cmd;
      f[NCMD_MSB:NCMD_LSB] = ~cmd;
      return f;
   endfunction

   function automatic logic is_mark(input state_t s);
      return (s == S_LEAD_M) || (s == S_BIT_M) || (s == S_STOP_M);
   endfunction
endpackage

// File: rtl/ir_transmit_if.sv
// Request/status bundle of the NEC IR transmitter; slave is the transmitter side.
interface ir_transmit_if;
   logic        iSTART;
   logic [15:0] iADDR;
   logic [7:0]  iCMD;
   logic        oBUSY;
   logic        oDONE;
   logic        oIRDA;
   logic        oIR_LED;

   modport master (output iSTART, iADDR, iCMD, input oBUSY, oDONE, oIRDA, oIR_LED);
   modport slave  (input iSTART, iADDR, iCMD, output oBUSY, oDONE, oIRDA, oIR_LED);
endinterface

// File: rtl/ir_carrier_gen.sv
// 50% duty IR carrier, phase restarted high on each mark entry; registered output, 0 when disabled.
module ir_carrier_gen
   import ir_nec_pkg::*;
#(
   parameter int unsigned HALF = CARRIER_HALF
)(
   input  logic iCLK,
   input  logic iRST,
   input  logic iEN,
   input  logic iRESTART,
   output logic oCARRIER
);
   localparam logic [CAR_CNT_W-1:0] W_LAST = CAR_CNT_W'(HALF - 1);

   logic [CAR_CNT_W-1:0] r_cnt;
   logic                 r_phase;
   logic                 r_out;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_cnt   <= '0;
         r_phase <= 1'b1;
         r_out   <= 1'b0;
      end else if (iRESTART) begin
         r_cnt   <= '0;
         r_phase <= 1'b1;
         r_out   <= 1'b1;
      end else if (iEN) begin
         if (r_cnt == W_LAST) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
            r_out   <= ~r_phase;
         end else begin
            r_cnt <= r_cnt + CAR_CNT_W'(1);
            r_out <= r_phase;
         end
      end else begin
         r_cnt <= '0;
         r_out <= 1'b0;
      end
   end

   assign oCARRIER = r_out;
endmodule

// File: rtl/ir_transmit.sv
// NEC IR transmitter: leader, 32 pulse-distance bits LSB first, stop mark, then idle-high gap.
// oIRDA/oIR_LED are registered from the next state so they align with the phase boundaries.
module ir_transmit
   import ir_nec_pkg::*;
#(
   parameter int unsigned P_LEAD_MARK    = LEAD_MARK,
   parameter int unsigned P_LEAD_SPACE   = LEAD_SPACE,
   parameter int unsigned P_BIT_MARK     = BIT_MARK,
   parameter int unsigned P_ZERO_SPACE   = ZERO_SPACE,
   parameter int unsigned P_ONE_SPACE    = ONE_SPACE,
   parameter int unsigned P_GAP_DUR      = GAP_DUR,
   parameter int unsigned P_CARRIER_HALF = CARRIER_HALF
)(
   input  logic         iCLK,
   input  logic         iRST,
   ir_transmit_if.slave bus
);
   localparam int unsigned CW = PH_CNT_W;

   state_t         r_state, w_state_nxt;
   logic [CW-1:0]  r_cnt, w_cnt_nxt, w_last;
   logic [4:0]     r_bit_idx, w_bit_idx_nxt;
   logic [31:0]    r_frame;
   logic           r_irda;
   logic           w_phase_end, w_accept, w_done, w_restart, w_carrier;

   always_comb begin
      w_last = '0;
      case (r_state)
         S_LEAD_M: w_last = CW'(P_LEAD_MARK - 1);
         S_LEAD_S: w_last = CW'(P_LEAD_SPACE - 1);
         S_BIT_M:  w_last = CW'(P_BIT_MARK - 1);
         S_BIT_S:  w_last = r_frame[r_bit_idx] ? CW'(P_ONE_SPACE - 1) : CW'(P_ZERO_SPACE - 1);
         S_STOP_M: w_last = CW'(P_BIT_MARK - 1);
         S_GAP:    w_last = CW'(P_GAP_DUR - 1);
         default:  w_last = '0;
      endcase
   end

   assign w_phase_end = (r_cnt == w_last);
   assign w_accept    = (r_state == S_IDLE) && bus.iSTART;
   assign w_done      = (r_state == S_GAP) && w_phase_end;

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt + CW'(1);
      w_bit_idx_nxt = r_bit_idx;
      case (r_state)
         S_IDLE: begin
            w_bit_idx_nxt = '0;
            if (w_accept) w_state_nxt = S_LEAD_M;
         end
         S_LEAD_M: if (w_phase_end) w_state_nxt = S_LEAD_S;
         S_LEAD_S: if (w_phase_end) w_state_nxt = S_BIT_M;
         S_BIT_M:  if (w_phase_end) w_state_nxt = S_BIT_S;
         S_BIT_S: begin
            if (w_phase_end) begin
               if (r_bit_idx == 5'd31) begin
                  w_state_nxt = S_STOP_M;
               end else begin
                  w_state_nxt   = S_BIT_M;
                  w_bit_idx_nxt = r_bit_idx + 5'd1;
               end
            end
         end
         S_STOP_M: if (w_phase_end) w_state_nxt = S_GAP;
         S_GAP:    if (w_phase_end) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
      // every phase transition is a state change, so this restarts the count on entry
      if (w_state_nxt != r_state) w_cnt_nxt = '0;
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_frame   <= '0;
         r_irda    <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_irda    <= ~is_mark(w_state_nxt);
         if (w_accept) r_frame <= nec_frame(bus.iADDR, bus.iCMD);
      end
   end

   // marks are only ever entered from a non-mark state
   assign w_restart = is_mark(w_state_nxt) && !is_mark(r_state);

   ir_carrier_gen #(.HALF(P_CARRIER_HALF)) u_carrier (
      .iCLK     (iCLK),
      .iRST     (iRST),
      .iEN      (is_mark(w_state_nxt)),
      .iRESTART (w_restart),
      .oCARRIER (w_carrier)
   );

   assign bus.oIRDA   = r_irda;
   assign bus.oIR_LED = w_carrier;
   assign bus.oDONE   = w_done;
   assign bus.oBUSY   = (r_state != S_IDLE) && !w_done;
endmodule

// File: tb/tb_ir_transmit.sv
// Directed bench for ir_transmit with shortened timing; decodes the oIRDA waveform like a receiver.
module tb_ir_transmit;
   localparam int LM = 20;
   localparam int LS = 10;
   localparam int BM = 3;
   localparam int ZS = 3;
   localparam int OS = 7;
   localparam int GD = 15;
   localparam int CH = 2;
   localparam int MAXC = 600;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   logic irda_a [0:MAXC];
   logic led_a  [0:MAXC];
   logic done_a [0:MAXC];
   logic busy_a [0:MAXC];

   ir_transmit_if bus();

   ir_transmit #(
      .P_LEAD_MARK(LM), .P_LEAD_SPACE(LS), .P_BIT_MARK(BM), .P_ZERO_SPACE(ZS),
      .P_ONE_SPACE(OS), .P_GAP_DUR(GD), .P_CARRIER_HALF(CH)
   ) dut (
      .iCLK (clk),
      .iRST (rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Records cycles 1..len after the accept edge; iSTART is driven per cycle.
   task automatic capture(input int len, input int inject_at, input logic [7:0] inj_cmd, input logic hold);
      for (int k = 1; k <= len; k++) begin
         irda_a[k] = bus.oIRDA;
         led_a[k]  = bus.oIR_LED;
         done_a[k] = bus.oDONE;
         busy_a[k] = bus.oBUSY;
         bus.iSTART = hold || (k == inject_at);
         if (k == inject_at) bus.iCMD = inj_cmd;
         step();
      end
      bus.iSTART = 1'b0;
   endtask

   task automatic decode(input int len, output logic [31:0] frame, output int lead_m,
                         output int lead_s, output int bad_bits, output int last_low,
                         output int first_done, output int n_done, output int led_bad);
      int   runs[$];
      int   run;
      logic lvl;
      frame = '0; bad_bits = 0; last_low = 0; first_done = 0; n_done = 0; led_bad = 0;
      lvl = irda_a[1];
      run = 0;
      for (int k = 1; k <= len; k++) begin
         if (irda_a[k] === lvl) run++;
         else begin
            runs.push_back(run);
            lvl = irda_a[k];
            run = 1;
         end
         if (irda_a[k] === 1'b0) last_low = k;
         if (done_a[k] === 1'b1) begin
            n_done++;
            if (first_done == 0) first_done = k;
         end
         if (irda_a[k] === 1'b1 && led_a[k] !== 1'b0) led_bad++;
         if (k > 1 && irda_a[k] === 1'b0 && irda_a[k-1] === 1'b1 && led_a[k] !== 1'b1) led_bad++;
         if (k <= LM && led_a[k] !== ((((k - 1) / CH) % 2) == 0)) led_bad++;
      end
      runs.push_back(run);
      lead_m = (irda_a[1] === 1'b0) ? runs[0] : -1;
      lead_s = (runs.size() > 1) ? runs[1] : -1;
      if (runs.size() < 67) begin
         bad_bits = 99;
      end else begin
         for (int i = 0; i < 32; i++) begin
            if (runs[2 + 2*i] != BM) bad_bits++;
            if (runs[3 + 2*i] == OS) frame[i] = 1'b1;
            else if (runs[3 + 2*i] != ZS) bad_bits++;
         end
         if (runs[66] != BM) bad_bits++;
      end
   endtask

   initial begin
      logic [31:0] fr;
      int lm, ls, bb, ll, fd, nd, lb, falls, lows;
      logic prev;

      bus.iSTART = 1'b0;
      bus.iADDR  = 16'h0000;
      bus.iCMD   = 8'h00;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("rst_irda", bus.oIRDA, 1);
      check("rst_led", bus.oIR_LED, 0);
      check("rst_busy", bus.oBUSY, 0);
      check("rst_done", bus.oDONE, 0);
      step();

      // loopback decode, timing and carrier for addr 00FF / cmd 45
      bus.iADDR = 16'h00FF;
      bus.iCMD  = 8'h45;
      bus.iSTART = 1'b1;
      step();
      bus.iSTART = 1'b0;
      check("t2_busy_first", bus.oBUSY, 1);
      check("t2_irda_first", bus.oIRDA, 0);
      capture(400, -1, 8'h00, 1'b0);
      decode(400, fr, lm, ls, bb, ll, fd, nd, lb);
      check("t1_frame", fr, 32'hBA4500FF);
      check("t2_lead_mark", lm, LM);
      check("t2_lead_space", ls, LS);
      check("t2_bit_timing", bb, 0);
      check("t2_stop_end", ll, 289);
      check("t2_done_at", fd, 304);
      check("t2_done_count", nd, 1);
      check("t2_busy_pre_done", busy_a[303], 1);
      check("t2_busy_at_done", busy_a[304], 0);
      check("t5_carrier", lb, 0);

      // iSTART during leader space must be ignored
      bus.iCMD = 8'h45;
      bus.iSTART = 1'b1;
      step();
      bus.iSTART = 1'b0;
      capture(400, 25, 8'h12, 1'b0);
      decode(400, fr, lm, ls, bb, ll, fd, nd, lb);
      check("t3_frame", fr, 32'hBA4500FF);
      check("t3_done_count", nd, 1);
      check("t3_no_second", ll, 289);

      // reset during bit 10 (12th falling edge: leader plus bits 0..10)
      bus.iADDR = 16'h1234;
      bus.iCMD  = 8'h56;
      bus.iSTART = 1'b1;
      step();
      bus.iSTART = 1'b0;
      falls = 0;
      prev = 1'b1;
      for (int k = 0; k < 400 && falls < 12; k++) begin
         if (prev === 1'b1 && bus.oIRDA === 1'b0) falls++;
         prev = bus.oIRDA;
         if (falls < 12) step();
      end
      check("t4_reach_bit10", falls, 12);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t4_irda", bus.oIRDA, 1);
      check("t4_led", bus.oIR_LED, 0);
      check("t4_busy", bus.oBUSY, 0);
      nd = 0;
      lows = 0;
      for (int k = 0; k < 100; k++) begin
         if (bus.oDONE !== 1'b0) nd++;
         if (bus.oIRDA !== 1'b1) lows++;
         step();
      end
      check("t4_no_done", nd, 0);
      check("t4_stays_idle", lows, 0);
      bus.iSTART = 1'b1;
      step();
      bus.iSTART = 1'b0;
      capture(400, -1, 8'h00, 1'b0);
      decode(400, fr, lm, ls, bb, ll, fd, nd, lb);
      check("t4_frame", fr, 32'hA9561234);
      check("t4_bit_timing", bb, 0);
      check("t4_done_at", fd, 292);

      // back-to-back with iSTART held
      bus.iADDR = 16'h0000;
      bus.iCMD  = 8'h00;
      bus.iSTART = 1'b1;
      step();
      capture(560, -1, 8'h00, 1'b1);
      nd = 0;
      fd = 0;
      ll = 0;
      for (int k = 1; k <= 560; k++) begin
         if (done_a[k] === 1'b1) begin
            nd++;
            if (nd == 1) fd = k;
            if (nd == 2) ll = k;
         end
      end
      check("t6_first_done", fd, 272);
      check("t6_idle_busy", busy_a[273], 0);
      check("t6_idle_irda", irda_a[273], 1);
      check("t6_refall_irda", irda_a[274], 0);
      check("t6_refall_busy", busy_a[274], 1);
      check("t6_second_done", ll, 545);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
